motor_arming_gate: RTL and testbench

Safety stage between `motor_mixer` and `pwm_generator`. Holds all four motor rates at zero until the pilot performs a timed arm gesture on the sticks, passes mixer rates through while armed, and returns to zero on a timed disarm gesture. Forces zero output (failsafe) when receiver throttle pulses stop arriving.

---
 rtl/motor_arming_gate_pkg.sv | 28 ++
 rtl/pwm_signal_monitor.sv | 51 +++++
 rtl/motor_arming_gate.sv | 131 +++++++++++++
 tb/tb_motor_arming_gate.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/motor_arming_gate_pkg.sv
// Shared types and defaults for the motor arming gate: state encoding,
// default gesture thresholds and timing constants.
package motor_arming_gate_pkg;

  localparam int MOTOR_RATE_BIT_WIDTH = 16;
  localparam int HOLD_CNT_WIDTH       = 20;

  localparam logic [7:0] THROTTLE_LOW_DEFAULT = 8'd10;
  localparam logic [7:0] YAW_ARM_DEFAULT      = 8'd245;
  localparam logic [7:0] YAW_DISARM_DEFAULT   = 8'd10;
  localparam int         HOLD_US_DEFAULT      = 1_000_000;
  localparam int         LOSS_US_DEFAULT      = 50_000;

  // Encoding is visible on the debug LEDs, so the values are fixed.
  typedef enum logic [2:0] {
    ARM_STATE_DISARMED    = 3'd0,
    ARM_STATE_ARM_WAIT    = 3'd1,
    ARM_STATE_ARMED       = 3'd2,
    ARM_STATE_DISARM_WAIT = 3'd3,
    ARM_STATE_FAILSAFE    = 3'd4
  } arm_state_t;

  // Motors may spin only in these two states.
  function automatic logic motors_enabled(arm_state_t s);
    return (s == ARM_STATE_ARMED) || (s == ARM_STATE_DISARM_WAIT);
  endfunction

endpackage

// File: rtl/pwm_signal_monitor.sv
// Receiver channel watchdog: synchronizes a raw PWM pin, detects rising
// edges and raises `lost` once LOSS_US ticks pass without one.
module pwm_signal_monitor #(
  parameter int LOSS_US = 50_000
) (
  input  logic us_clk,
  input  logic resetn,
  input  logic pwm,
  output logic lost
);

  localparam int                CNT_W    = $clog2(LOSS_US + 1);
  localparam logic [CNT_W-1:0]  LOSS_MAX = CNT_W'(LOSS_US);

  logic             sync_1;
  logic             sync_2;
  logic             sync_3;
  logic             rise;
  logic [CNT_W-1:0] loss_cnt;

  // Two-flop synchronizer plus one delay stage for edge detection.
  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      sync_3 <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make each stage take the previous
      // stage's old value; blocking would collapse the chain into one flop.
      sync_1 <= pwm;
      sync_2 <= sync_1;
      sync_3 <= sync_2;
    end
  end

  assign rise = sync_2 & ~sync_3;

  // Loss counter: cleared by every edge, otherwise counts up and saturates.
  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) begin
      loss_cnt <= '0;
    end else if (rise) begin
      loss_cnt <= '0;
    end else if (loss_cnt != LOSS_MAX) begin
      loss_cnt <= loss_cnt + 1'b1;
    end
  end

  assign lost = (loss_cnt == LOSS_MAX);

endmodule

// File: rtl/motor_arming_gate.sv
// Safety gate between the mixer and the PWM generator: motors stay at zero
// until a held arm gesture, pass through while armed, and drop to zero on a
// held disarm gesture or when throttle pulses stop arriving.
module motor_arming_gate
  import motor_arming_gate_pkg::*;
#(
  parameter int                         RATE_WIDTH        = MOTOR_RATE_BIT_WIDTH,
  parameter int                         REC_VAL_BIT_WIDTH = 8,
  parameter logic [REC_VAL_BIT_WIDTH-1:0] THROTTLE_LOW    = THROTTLE_LOW_DEFAULT,
  parameter logic [REC_VAL_BIT_WIDTH-1:0] YAW_ARM         = YAW_ARM_DEFAULT,
  parameter logic [REC_VAL_BIT_WIDTH-1:0] YAW_DISARM      = YAW_DISARM_DEFAULT,
  parameter int                         HOLD_US           = HOLD_US_DEFAULT,
  parameter int                         LOSS_US           = LOSS_US_DEFAULT
) (
  input  logic                         us_clk,
  input  logic                         resetn,
  input  logic                         throttle_pwm,
  input  logic [REC_VAL_BIT_WIDTH-1:0] throttle_val,
  input  logic [REC_VAL_BIT_WIDTH-1:0] yaw_val,
  input  logic [RATE_WIDTH-1:0]        motor_1_rate_in,
  input  logic [RATE_WIDTH-1:0]        motor_2_rate_in,
  input  logic [RATE_WIDTH-1:0]        motor_3_rate_in,
  input  logic [RATE_WIDTH-1:0]        motor_4_rate_in,
  output logic [RATE_WIDTH-1:0]        motor_1_rate_out,
  output logic [RATE_WIDTH-1:0]        motor_2_rate_out,
  output logic [RATE_WIDTH-1:0]        motor_3_rate_out,
  output logic [RATE_WIDTH-1:0]        motor_4_rate_out,
  output logic                         armed,
  output logic                         failsafe,
  output logic [2:0]                   state
);

  localparam logic [HOLD_CNT_WIDTH-1:0] HOLD_LAST = HOLD_CNT_WIDTH'(HOLD_US - 1);

  arm_state_t                state_q;
  arm_state_t                next_state;
  logic [HOLD_CNT_WIDTH-1:0] hold_cnt;
  logic                      lost;
  logic                      throttle_low;
  logic                      arm_g;
  logic                      disarm_g;
  logic                      hold_done;

  pwm_signal_monitor #(
    .LOSS_US (LOSS_US)
  ) u_throttle_monitor (
    .us_clk (us_clk),
    .resetn (resetn),
    .pwm    (throttle_pwm),
    .lost   (lost)
  );

  assign throttle_low = (throttle_val <= THROTTLE_LOW);
  assign arm_g        = throttle_low && (yaw_val >= YAW_ARM);
  assign disarm_g     = throttle_low && (yaw_val <= YAW_DISARM);
  assign hold_done    = (hold_cnt == HOLD_LAST);

  // Next-state logic; loss of signal overrides everything outside FAILSAFE,
  // and a released gesture beats a completing hold count.
  always_comb begin
    // NOTE: default first so every path assigns next_state and no latch forms.
    next_state = state_q;
    case (state_q)
      ARM_STATE_DISARMED: begin
        if (lost)       next_state = ARM_STATE_FAILSAFE;
        else if (arm_g) next_state = ARM_STATE_ARM_WAIT;
      end
      ARM_STATE_ARM_WAIT: begin
        if (lost)           next_state = ARM_STATE_FAILSAFE;
        else if (!arm_g)    next_state = ARM_STATE_DISARMED;
        else if (hold_done) next_state = ARM_STATE_ARMED;
      end
      ARM_STATE_ARMED: begin
        if (lost)          next_state = ARM_STATE_FAILSAFE;
        else if (disarm_g) next_state = ARM_STATE_DISARM_WAIT;
      end
      ARM_STATE_DISARM_WAIT: begin
        if (lost)           next_state = ARM_STATE_FAILSAFE;
        else if (!disarm_g) next_state = ARM_STATE_ARMED;
        else if (hold_done) next_state = ARM_STATE_DISARMED;
      end
      ARM_STATE_FAILSAFE: begin
        if (!lost && throttle_low) next_state = ARM_STATE_DISARMED;
      end
      default: next_state = ARM_STATE_FAILSAFE;
    endcase
  end

  // State, hold timer and gated outputs, all updated from next_state so the
  // motors stop on the very edge a safe state is entered.
  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) begin
      state_q          <= ARM_STATE_DISARMED;
      hold_cnt         <= '0;
      armed            <= 1'b0;
      failsafe         <= 1'b0;
      motor_1_rate_out <= '0;
      motor_2_rate_out <= '0;
      motor_3_rate_out <= '0;
      motor_4_rate_out <= '0;
    end else begin
      state_q  <= next_state;
      armed    <= motors_enabled(next_state);
      failsafe <= (next_state == ARM_STATE_FAILSAFE);

      if (next_state != state_q) begin
        hold_cnt <= '0;
      end else if ((state_q == ARM_STATE_ARM_WAIT) ||
                   (state_q == ARM_STATE_DISARM_WAIT)) begin
        hold_cnt <= hold_cnt + 1'b1;
      end else begin
        hold_cnt <= '0;
      end

      if (motors_enabled(next_state)) begin
        motor_1_rate_out <= motor_1_rate_in;
        motor_2_rate_out <= motor_2_rate_in;
        motor_3_rate_out <= motor_3_rate_in;
        motor_4_rate_out <= motor_4_rate_in;
      end else begin
        motor_1_rate_out <= '0;
        motor_2_rate_out <= '0;
        motor_3_rate_out <= '0;
        motor_4_rate_out <= '0;
      end
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_motor_arming_gate.sv
// Directed bench for motor_arming_gate with HOLD_US=100 and LOSS_US=50.
module tb_motor_arming_gate;

  logic        us_clk;
  logic        resetn;
  logic        throttle_pwm;
  logic [7:0]  throttle_val;
  logic [7:0]  yaw_val;
  logic [15:0] rate_in_1, rate_in_2, rate_in_3, rate_in_4;
  logic [15:0] rate_out_1, rate_out_2, rate_out_3, rate_out_4;
  logic        armed;
  logic        failsafe;
  logic [2:0]  state;

  logic pulse_en;
  logic gen_pwm;
  logic manual_pwm;
  int   pcnt;

  int checks = 0;
  int errors = 0;

  localparam logic [2:0] S_DISARMED = 3'd0;
  localparam logic [2:0] S_ARM_WAIT = 3'd1;
  localparam logic [2:0] S_ARMED    = 3'd2;
  localparam logic [2:0] S_DIS_WAIT = 3'd3;
  localparam logic [2:0] S_FAIL     = 3'd4;

  assign throttle_pwm = pulse_en ? gen_pwm : manual_pwm;

  motor_arming_gate #(
    .RATE_WIDTH        (16),
    .REC_VAL_BIT_WIDTH (8),
    .HOLD_US           (100),
    .LOSS_US           (50)
  ) dut (
    .us_clk           (us_clk),
    .resetn           (resetn),
    .throttle_pwm     (throttle_pwm),
    .throttle_val     (throttle_val),
    .yaw_val          (yaw_val),
    .motor_1_rate_in  (rate_in_1),
    .motor_2_rate_in  (rate_in_2),
    .motor_3_rate_in  (rate_in_3),
    .motor_4_rate_in  (rate_in_4),
    .motor_1_rate_out (rate_out_1),
    .motor_2_rate_out (rate_out_2),
    .motor_3_rate_out (rate_out_3),
    .motor_4_rate_out (rate_out_4),
    .armed            (armed),
    .failsafe         (failsafe),
    .state            (state)
  );

  initial begin
    us_clk = 1'b0;
    forever #5 us_clk = ~us_clk;
  end

  // Receiver throttle pulse: 5 ticks high every 20 ticks while enabled.
  initial begin
    gen_pwm = 1'b0;
    pcnt    = 0;
    forever begin
      @(posedge us_clk);
      #1;
      if (pulse_en) begin
        gen_pwm = (pcnt < 5);
        pcnt    = (pcnt + 1) % 20;
      end else begin
        gen_pwm = 1'b0;
        pcnt    = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic check_rates(input string tag, input logic [15:0] e1,
                             input logic [15:0] e2, input logic [15:0] e3,
                             input logic [15:0] e4);
    check({tag, ".m1"}, rate_out_1, e1);
    check({tag, ".m2"}, rate_out_2, e2);
    check({tag, ".m3"}, rate_out_3, e3);
    check({tag, ".m4"}, rate_out_4, e4);
  endtask

  // Advance n active edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge us_clk);
      #1;
    end
  endtask

  initial begin
    resetn       = 1'b0;
    pulse_en     = 1'b0;
    manual_pwm   = 1'b0;
    throttle_val = 8'd0;
    yaw_val      = 8'd128;
    rate_in_1    = 16'h0400;
    rate_in_2    = 16'h0401;
    rate_in_3    = 16'h0402;
    rate_in_4    = 16'h0403;

    // Reset values.
    tick(3);
    check("rst.state", state, S_DISARMED);
    check("rst.armed", armed, 1'b0);
    check("rst.failsafe", failsafe, 1'b0);
    check_rates("rst.rates", 16'h0, 16'h0, 16'h0, 16'h0);

    // No pulses after reset: the loss counter reaches 50 on the 50th edge,
    // so FAILSAFE is registered on the 51st.
    resetn = 1'b1;
    tick(50);
    check("nopulse.before", failsafe, 1'b0);
    check("nopulse.state_before", state, S_DISARMED);
    tick(1);
    check("nopulse.failsafe", failsafe, 1'b1);
    check("nopulse.state", state, S_FAIL);

    // Fresh reset with regular pulses and neutral sticks: stays disarmed.
    resetn = 1'b0;
    tick(2);
    resetn   = 1'b1;
    pulse_en = 1'b1;
    tick(60);
    check("idle.state", state, S_DISARMED);
    check("idle.failsafe", failsafe, 1'b0);
    check_rates("idle.rates", 16'h0, 16'h0, 16'h0, 16'h0);

    // Aborted arm: ARM_WAIT on edge 1, hold reaches 99 on edge 100; releasing
    // yaw then returns to DISARMED on edge 101.
    throttle_val = 8'd5;
    yaw_val      = 8'd250;
    tick(1);
    check("abort.wait", state, S_ARM_WAIT);
    tick(99);
    check("abort.wait99", state, S_ARM_WAIT);
    yaw_val = 8'd128;
    tick(1);
    check("abort.state", state, S_DISARMED);
    check("abort.armed", armed, 1'b0);
    check_rates("abort.rates", 16'h0, 16'h0, 16'h0, 16'h0);

    // Full arm: ARMED exactly 100 edges after ARM_WAIT, outputs on that edge.
    yaw_val = 8'd250;
    tick(1);
    check("arm.wait", state, S_ARM_WAIT);
    tick(99);
    check("arm.wait99", state, S_ARM_WAIT);
    check("arm.wait99_out", rate_out_1, 16'h0);
    tick(1);
    check("arm.state", state, S_ARMED);
    check("arm.armed", armed, 1'b1);
    check_rates("arm.rates", 16'h0400, 16'h0401, 16'h0402, 16'h0403);
    yaw_val = 8'd128;

    // Pass-through is registered: new inputs appear on the next edge only.
    rate_in_1 = 16'h1111;
    rate_in_2 = 16'h2222;
    rate_in_3 = 16'h3333;
    rate_in_4 = 16'h4444;
    #1;
    check("pass.held", rate_out_1, 16'h0400);
    tick(1);
    check_rates("pass.rates", 16'h1111, 16'h2222, 16'h3333, 16'h4444);

    // Disarm gesture released at hold count 50: back to ARMED.
    yaw_val = 8'd3;
    tick(1);
    check("dis_rel.wait", state, S_DIS_WAIT);
    check("dis_rel.armed", armed, 1'b1);
    check("dis_rel.out", rate_out_4, 16'h4444);
    tick(50);
    check("dis_rel.wait50", state, S_DIS_WAIT);
    yaw_val = 8'd128;
    tick(1);
    check("dis_rel.state", state, S_ARMED);

    // Full disarm.
    yaw_val = 8'd3;
    tick(1);
    check("disarm.wait", state, S_DIS_WAIT);
    tick(99);
    check("disarm.wait99", state, S_DIS_WAIT);
    check("disarm.wait99_out", rate_out_2, 16'h2222);
    tick(1);
    check("disarm.state", state, S_DISARMED);
    check("disarm.armed", armed, 1'b0);
    check_rates("disarm.rates", 16'h0, 16'h0, 16'h0, 16'h0);

    // Re-arm for the loss test.
    yaw_val = 8'd250;
    tick(101);
    check("rearm.state", state, S_ARMED);
    yaw_val = 8'd128;

    // Signal loss while ARMED. One manual pulse: sampled on edge 0, rise seen
    // after edge 1, counter cleared on edge 2, reaches 50 on edge 52, and
    // FAILSAFE lands on edge 53 (the 52nd edge after the detected rise).
    pulse_en   = 1'b0;
    manual_pwm = 1'b0;
    tick(4);
    manual_pwm = 1'b1;
    tick(1);
    tick(3);
    manual_pwm = 1'b0;
    tick(49);
    check("loss.before_fs", failsafe, 1'b0);
    check("loss.before_state", state, S_ARMED);
    check("loss.before_out", rate_out_3, 16'h3333);
    tick(1);
    check("loss.failsafe", failsafe, 1'b1);
    check("loss.state", state, S_FAIL);
    check("loss.armed", armed, 1'b0);
    check_rates("loss.rates", 16'h0, 16'h0, 16'h0, 16'h0);

    // Pulses return with throttle high: must stay in FAILSAFE.
    throttle_val = 8'd200;
    pulse_en     = 1'b1;
    tick(40);
    check("recov.hi_state", state, S_FAIL);
    check("recov.hi_fs", failsafe, 1'b1);
    check("recov.hi_out", rate_out_1, 16'h0);

    // Throttle low: DISARMED, and never ARMED without a fresh gesture.
    throttle_val = 8'd5;
    yaw_val      = 8'd128;
    tick(1);
    check("recov.state", state, S_DISARMED);
    check("recov.fs", failsafe, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check("recov.hold_state", state, S_DISARMED);
      check("recov.hold_armed", armed, 1'b0);
    end

    // Asynchronous reset while ARMED clears outputs without a clock edge.
    yaw_val = 8'd250;
    tick(101);
    check("areset.armed_state", state, S_ARMED);
    yaw_val = 8'd128;
    tick(1);
    check("areset.pre_out", rate_out_1, 16'h1111);
    resetn = 1'b0;
    #1;
    check("areset.state", state, S_DISARMED);
    check("areset.armed", armed, 1'b0);
    check_rates("areset.rates", 16'h0, 16'h0, 16'h0, 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
